// File: rtl/gate_reduce_bist.sv
// BIST sequencer for the 4-bit gate-reduction unit: sweeps vectors 0..15, samples after settle, reports a verdict.
// Latency: 16*(SETTLE_CYCLES+2)+1 cycles from start to done; start is ignored while busy, and abort cancels a run.
module gate_reduce_bist #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [3:0]           in_o,
  input  logic                 out_and_i,
  input  logic                 out_or_i,
  input  logic                 out_xor_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 first_err_valid,
  output logic [3:0]           first_err_vec
);

  localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0]     CNT_RELOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX    = {ERR_CNT_W{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_SAMPLE, S_DONE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     settle_cnt;
  logic                 exp_and, exp_or, exp_xor;
  logic                 mismatch;
  logic [ERR_CNT_W-1:0] err_next;

  // in_o doubles as the current vector: it is only nonzero while a run is active.
  always_comb begin
    exp_and  = &in_o;
    exp_or   = |in_o;
    exp_xor  = in_o[1] ^ in_o[3];
    mismatch = (out_and_i != exp_and) || (out_or_i != exp_or) || (out_xor_i != exp_xor);
    err_next = err_count;
    if (mismatch && (err_count != ERR_MAX))
      err_next = err_count + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      settle_cnt      <= '0;
      in_o            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state           <= S_HOLD;
            in_o            <= '0;
            settle_cnt      <= CNT_RELOAD;
            busy            <= 1'b1;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
          end
        end
        S_HOLD: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            in_o  <= '0;
            pass  <= 1'b0;
          end else if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end else begin
            state <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            in_o  <= '0;
            pass  <= 1'b0;
          end else begin
            err_count <= err_next;
            if (mismatch && !first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_vec   <= in_o;
            end
            if (in_o == 4'hF) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
              in_o  <= '0;
              pass  <= (err_next == '0);
            end else begin
              state      <= S_HOLD;
              in_o       <= in_o + 4'd1;
              settle_cnt <= CNT_RELOAD;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_reduce_bist.sv
// Directed bench for gate_reduce_bist: three instances (default, SETTLE_CYCLES=0, ERR_CNT_W=3) each driving a model unit.
module tb_gate_reduce_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic [2:0] start_v = 3'b000;
  logic [2:0] done_v, busy_v, pass_v, fev_v;
  logic [3:0] in_a, in_b, in_c, fvec_a, fvec_b, fvec_c;
  logic [4:0] err_a, err_b;
  logic [2:0] err_c;
  logic [2:0] unit_a, unit_b, unit_c, dly1, dly2;
  int mode_a = 0;
  int mode_b = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [2:0] gold(input logic [3:0] v);
    return {&v, |v, v[1] ^ v[3]};
  endfunction

  // mode_a: 0 golden, 1 out_and stuck-at-0, 2 out_xor inverted
  always_comb begin
    unit_a = gold(in_a);
    if (mode_a == 1) unit_a[2] = 1'b0;
    if (mode_a == 2) unit_a[0] = ~unit_a[0];
    unit_c    = gold(in_c);
    unit_c[0] = ~unit_c[0];
    unit_b    = (mode_b == 1) ? dly1 : (mode_b == 2) ? dly2 : gold(in_b);
  end

  always_ff @(posedge clk) begin
    dly1 <= gold(in_b);
    dly2 <= dly1;
  end

  gate_reduce_bist dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort), .in_o(in_a),
    .out_and_i(unit_a[2]), .out_or_i(unit_a[1]), .out_xor_i(unit_a[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_a),
    .first_err_valid(fev_v[0]), .first_err_vec(fvec_a));

  gate_reduce_bist #(.SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort), .in_o(in_b),
    .out_and_i(unit_b[2]), .out_or_i(unit_b[1]), .out_xor_i(unit_b[0]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_b),
    .first_err_valid(fev_v[1]), .first_err_vec(fvec_b));

  gate_reduce_bist #(.ERR_CNT_W(3)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort), .in_o(in_c),
    .out_and_i(unit_c[2]), .out_or_i(unit_c[1]), .out_xor_i(unit_c[0]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_c),
    .first_err_valid(fev_v[2]), .first_err_vec(fvec_c));

  // Start accepted at the following edge k; returns at the negedge inside cycle k+1.
  task automatic pulse_start(input int idx, input logic with_abort);
    @(negedge clk);
    start_v[idx] = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start_v[idx] = 1'b0;
    abort = 1'b0;
  endtask

  // Called in cycle k+1; counts cycles until done, optionally re-pulsing start at cycle k+restart_at.
  task automatic wait_done(input int idx, input int exp_lat, input int restart_at);
    int lat;
    lat = 0;
    for (int j = 1; j <= 150; j++) begin
      if (j > 1) @(negedge clk);
      start_v[idx] = (j == restart_at);
      if (done_v[idx]) begin
        lat = j;
        break;
      end
    end
    start_v[idx] = 1'b0;
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL done_latency dut%0d: got %0d (0 = timeout), want %0d", idx, lat, exp_lat);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({in_a, busy_v[0], done_v[0], pass_v[0], err_a, fev_v[0], fvec_a} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, want 0", {in_a, busy_v[0], done_v[0], pass_v[0], err_a, fev_v[0], fvec_a});
    end
  endtask

  task automatic test_golden_sweep;
    int bad;
    mode_a = 0;
    bad = 0;
    pulse_start(0, 1'b0);
    for (int j = 1; j <= 52; j++) begin
      if (j > 1) @(negedge clk);
      if (j <= 48) begin
        if (in_a !== 4'((j - 1) / 3) || busy_v[0] !== 1'b1 || done_v[0] !== 1'b0) bad++;
      end else if (j == 49) begin
        if (in_a !== 4'd0 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b1) bad++;
      end else if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL golden_trace: %0d bad cycles, want 0", bad);
    end
    checks++;
    if ({pass_v[0], err_a, fev_v[0]} !== {1'b1, 5'd0, 1'b0}) begin
      errors++;
      $display("FAIL golden_verdict: pass=%b err=%0d fev=%b, want 1 0 0", pass_v[0], err_a, fev_v[0]);
    end
  endtask

  task automatic test_and_stuck;
    mode_a = 1;
    pulse_start(0, 1'b0);
    wait_done(0, 49, 0);
    checks++;
    if ({pass_v[0], err_a, fev_v[0], fvec_a} !== {1'b0, 5'd1, 1'b1, 4'hF}) begin
      errors++;
      $display("FAIL and_stuck: pass=%b err=%0d fev=%b fvec=%h, want 0 1 1 f", pass_v[0], err_a, fev_v[0], fvec_a);
    end
    mode_a = 0;
  endtask

  task automatic test_xor_invert;
    mode_a = 2;
    fork
      pulse_start(0, 1'b0);
      pulse_start(2, 1'b0);
    join
    wait_done(0, 49, 0);
    checks++;
    if ({pass_v[0], err_a, fev_v[0], fvec_a} !== {1'b0, 5'd16, 1'b1, 4'h0}) begin
      errors++;
      $display("FAIL xor_invert: pass=%b err=%0d fev=%b fvec=%h, want 0 16 1 0", pass_v[0], err_a, fev_v[0], fvec_a);
    end
    checks++;
    if ({pass_v[2], err_c} !== {1'b0, 3'd7}) begin
      errors++;
      $display("FAIL err_saturate: pass=%b err=%0d, want 0 7", pass_v[2], err_c);
    end
    mode_a = 0;
  endtask

  task automatic test_settle0;
    mode_b = 1;
    pulse_start(1, 1'b0);
    wait_done(1, 33, 0);
    checks++;
    if ({pass_v[1], err_b} !== {1'b1, 5'd0}) begin
      errors++;
      $display("FAIL delay1_pass: pass=%b err=%0d, want 1 0", pass_v[1], err_b);
    end
    mode_b = 2;
    pulse_start(1, 1'b0);
    wait_done(1, 33, 0);
    checks++;
    if ({pass_v[1], fev_v[1], fvec_b} !== {1'b0, 1'b1, 4'h1}) begin
      errors++;
      $display("FAIL delay2_fail: pass=%b fev=%b fvec=%h, want 0 1 1", pass_v[1], fev_v[1], fvec_b);
    end
    mode_b = 0;
  endtask

  task automatic test_start_while_busy;
    pulse_start(0, 1'b0);
    wait_done(0, 49, 19);
    checks++;
    if (pass_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL restart_pass: got %b, want 1", pass_v[0]);
    end
  endtask

  task automatic test_abort;
    int seen_done;
    pulse_start(0, 1'b1);
    checks++;
    if (busy_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL start_beats_abort: busy=%b, want 1", busy_v[0]);
    end
    for (int j = 2; j <= 28; j++) @(negedge clk);
    checks++;
    if (in_a !== 4'd9) begin
      errors++;
      $display("FAIL abort_setup: in_o=%0d, want 9", in_a);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({busy_v[0], in_a, pass_v[0], done_v[0]} !== 7'd0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b in_o=%0d pass=%b done=%b, want 0 0 0 0", busy_v[0], in_a, pass_v[0], done_v[0]);
    end
    seen_done = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL abort_no_done: %0d active cycles after abort, want 0", seen_done);
    end
  endtask

  task automatic test_reset_mid_run;
    mode_a = 1;
    pulse_start(0, 1'b0);
    for (int j = 2; j <= 16; j++) @(negedge clk);
    checks++;
    if (in_a !== 4'd5) begin
      errors++;
      $display("FAIL reset_setup: in_o=%0d, want 5", in_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_a, busy_v[0], done_v[0], pass_v[0], err_a, fev_v[0], fvec_a} !== 17'd0) begin
      errors++;
      $display("FAIL async_reset: got %h, want 0", {in_a, busy_v[0], done_v[0], pass_v[0], err_a, fev_v[0], fvec_a});
    end
    @(negedge clk);
    rst_n = 1'b1;
    mode_a = 0;
    pulse_start(0, 1'b0);
    checks++;
    if (in_a !== 4'd0 || busy_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL restart_from_zero: in_o=%0d busy=%b, want 0 1", in_a, busy_v[0]);
    end
    wait_done(0, 49, 0);
    checks++;
    if ({pass_v[0], err_a} !== {1'b1, 5'd0}) begin
      errors++;
      $display("FAIL post_reset_pass: pass=%b err=%0d, want 1 0", pass_v[0], err_a);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    test_golden_sweep();
    test_and_stuck();
    test_xor_invert();
    test_settle0();
    test_start_while_busy();
    test_abort();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
